// File: rtl/cam_forwarding_controller.sv
// Round-robin learn/lookup sequencer that serialises per-port frame requests onto one cam_table.
// Optional feature macro: CAM_BROADCAST_BYPASS_EN (all-ones destination skips the DST lookup).
module cam_forwarding_controller #(
    parameter int NUM_PORTS   = 4,
    parameter int KEY_WIDTH   = 48,
    parameter int TABLE_DEPTH = 32,
    parameter int INDEX_DEPTH = 8,
    localparam int IW = $clog2(INDEX_DEPTH),
    localparam int PW = $clog2(NUM_PORTS),
    localparam int CW = $clog2(TABLE_DEPTH + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           req_valid,
    output logic [NUM_PORTS-1:0]           req_ready,
    input  logic [NUM_PORTS*KEY_WIDTH-1:0] req_src_key,
    input  logic [NUM_PORTS*KEY_WIDTH-1:0] req_dst_key,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [PW-1:0]                  resp_port,
    output logic [IW-1:0]                  resp_dest_index,
    output logic                           resp_flood,
    output logic                           cam_write_enable,
    output logic                           cam_match_enable,
    output logic [KEY_WIDTH-1:0]           cam_key,
    output logic [IW-1:0]                  cam_index,
    input  logic [IW-1:0]                  cam_match_index,
    input  logic                           cam_match_valid,
    input  logic                           cam_no_match,
    output logic [CW-1:0]                  learned_count,
    output logic                           table_full
);

    typedef enum logic [2:0] {
        IDLE, SRC_LOOKUP, SRC_CHECK, LEARN, DST_LOOKUP, DST_CHECK, RESPOND
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   req_ready_q, req_ready_d;
    logic [PW-1:0]          grant_port_q, grant_port_d;
    logic [PW-1:0]          last_grant_q, last_grant_d;
    logic [KEY_WIDTH-1:0]   src_q, src_d;
    logic [KEY_WIDTH-1:0]   dst_q, dst_d;
    logic [PW-1:0]          port_q, port_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [PW-1:0]          resp_port_q, resp_port_d;
    logic [IW-1:0]          resp_dest_index_q, resp_dest_index_d;
    logic                   resp_flood_q, resp_flood_d;
    logic                   cam_write_enable_q, cam_write_enable_d;
    logic                   cam_match_enable_q, cam_match_enable_d;
    logic [KEY_WIDTH-1:0]   cam_key_q, cam_key_d;
    logic [IW-1:0]          cam_index_q, cam_index_d;
    logic [CW-1:0]          learned_count_q, learned_count_d;
    logic                   table_full_q, table_full_d;

    logic [KEY_WIDTH-1:0]   src_keys [NUM_PORTS];
    logic [KEY_WIDTH-1:0]   dst_keys [NUM_PORTS];
    logic                   pick_found;
    logic [PW-1:0]          pick_port;
    logic [NUM_PORTS-1:0]   pick_onehot;
    logic                   xfer;
    logic                   dst_is_bcast;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign src_keys[gi] = req_src_key[gi*KEY_WIDTH +: KEY_WIDTH];
        assign dst_keys[gi] = req_dst_key[gi*KEY_WIDTH +: KEY_WIDTH];
    end

`ifdef CAM_BROADCAST_BYPASS_EN
    assign dst_is_bcast = (dst_q == {KEY_WIDTH{1'b1}});
`else
    assign dst_is_bcast = 1'b0;
`endif

    // Search starts one past the last accepted port so every requester gets a turn.
    always_comb begin
        pick_found = 1'b0;
        pick_port  = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            if (!pick_found && req_valid[(int'(last_grant_q) + i) % NUM_PORTS]) begin
                pick_found = 1'b1;
                pick_port  = PW'((int'(last_grant_q) + i) % NUM_PORTS);
            end
        end
        pick_onehot = pick_found ? (NUM_PORTS'(1) << pick_port) : '0;
    end

    assign xfer = |(req_valid & req_ready_q);

    // Outputs are computed for the state being entered so they leave the block registered.
    always_comb begin
        state_d            = state_q;
        req_ready_d        = '0;
        grant_port_d       = grant_port_q;
        last_grant_d       = last_grant_q;
        src_d              = src_q;
        dst_d              = dst_q;
        port_d             = port_q;
        resp_valid_d       = 1'b0;
        resp_port_d        = resp_port_q;
        resp_dest_index_d  = resp_dest_index_q;
        resp_flood_d       = resp_flood_q;
        cam_write_enable_d = 1'b0;
        cam_match_enable_d = 1'b0;
        cam_key_d          = '0;
        cam_index_d        = '0;
        learned_count_d    = learned_count_q;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d            = SRC_LOOKUP;
                    src_d              = src_keys[grant_port_q];
                    dst_d              = dst_keys[grant_port_q];
                    port_d             = grant_port_q;
                    last_grant_d       = grant_port_q;
                    cam_match_enable_d = 1'b1;
                    cam_key_d          = src_keys[grant_port_q];
                end else begin
                    req_ready_d  = pick_onehot;
                    grant_port_d = pick_port;
                end
            end
            SRC_LOOKUP: state_d = SRC_CHECK;
            SRC_CHECK: begin
                if (cam_no_match && !table_full_q) begin
                    state_d            = LEARN;
                    cam_write_enable_d = 1'b1;
                    cam_key_d          = src_q;
                    cam_index_d        = IW'(port_q);
                end else if (dst_is_bcast) begin
                    state_d           = RESPOND;
                    resp_valid_d      = 1'b1;
                    resp_port_d       = port_q;
                    resp_flood_d      = 1'b1;
                    resp_dest_index_d = '0;
                end else begin
                    state_d            = DST_LOOKUP;
                    cam_match_enable_d = 1'b1;
                    cam_key_d          = dst_q;
                end
            end
            LEARN: begin
                if (learned_count_q != CW'(TABLE_DEPTH)) begin
                    learned_count_d = learned_count_q + CW'(1);
                end
                if (dst_is_bcast) begin
                    state_d           = RESPOND;
                    resp_valid_d      = 1'b1;
                    resp_port_d       = port_q;
                    resp_flood_d      = 1'b1;
                    resp_dest_index_d = '0;
                end else begin
                    state_d            = DST_LOOKUP;
                    cam_match_enable_d = 1'b1;
                    cam_key_d          = dst_q;
                end
            end
            DST_LOOKUP: state_d = DST_CHECK;
            DST_CHECK: begin
                state_d      = RESPOND;
                resp_valid_d = 1'b1;
                resp_port_d  = port_q;
                if (cam_match_valid) begin
                    resp_flood_d      = 1'b0;
                    resp_dest_index_d = cam_match_index;
                end else begin
                    resp_flood_d      = 1'b1;
                    resp_dest_index_d = '0;
                end
            end
            RESPOND: begin
                if (resp_ready) begin
                    // Grant is prepared here so the IDLE cycle after acceptance already carries it.
                    state_d      = IDLE;
                    req_ready_d  = pick_onehot;
                    grant_port_d = pick_port;
                end else begin
                    resp_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        table_full_d = (learned_count_d == CW'(TABLE_DEPTH));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q            <= IDLE;
            req_ready_q        <= '0;
            grant_port_q       <= '0;
            last_grant_q       <= PW'(NUM_PORTS - 1);
            src_q              <= '0;
            dst_q              <= '0;
            port_q             <= '0;
            resp_valid_q       <= 1'b0;
            resp_port_q        <= '0;
            resp_dest_index_q  <= '0;
            resp_flood_q       <= 1'b0;
            cam_write_enable_q <= 1'b0;
            cam_match_enable_q <= 1'b0;
            cam_key_q          <= '0;
            cam_index_q        <= '0;
            learned_count_q    <= '0;
            table_full_q       <= 1'b0;
        end else begin
            state_q            <= state_d;
            req_ready_q        <= req_ready_d;
            grant_port_q       <= grant_port_d;
            last_grant_q       <= last_grant_d;
            src_q              <= src_d;
            dst_q              <= dst_d;
            port_q             <= port_d;
            resp_valid_q       <= resp_valid_d;
            resp_port_q        <= resp_port_d;
            resp_dest_index_q  <= resp_dest_index_d;
            resp_flood_q       <= resp_flood_d;
            cam_write_enable_q <= cam_write_enable_d;
            cam_match_enable_q <= cam_match_enable_d;
            cam_key_q          <= cam_key_d;
            cam_index_q        <= cam_index_d;
            learned_count_q    <= learned_count_d;
            table_full_q       <= table_full_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_port        = resp_port_q;
    assign resp_dest_index  = resp_dest_index_q;
    assign resp_flood       = resp_flood_q;
    assign cam_write_enable = cam_write_enable_q;
    assign cam_match_enable = cam_match_enable_q;
    assign cam_key          = cam_key_q;
    assign cam_index        = cam_index_q;
    assign learned_count    = learned_count_q;
    assign table_full       = table_full_q;

endmodule

// File: doc/cam_forwarding_controller.md
# cam_forwarding_controller

Sequences source-learn and destination-lookup transactions from NUM_PORTS ingress ports onto a single `cam_table` instance, one transaction at a time. It sits between the per-port frame parsers and the CAM inside the switch core. It arbitrates round-robin and enforces lookup-before-write so that no duplicate key enters the CAM. It tracks table occupancy and returns a forwarding decision (destination index or flood) per frame.

## Interface
- NUM_PORTS, 4, number of requesting ingress ports; must be ≤ INDEX_DEPTH
- KEY_WIDTH, 48, MAC key width
- TABLE_DEPTH, 32, CAM entry count; must match the attached CAM
- INDEX_DEPTH, 8, CAM index range; IW = $clog2(INDEX_DEPTH), PW = $clog2(NUM_PORTS)

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; resets all state
- req_valid  in  NUM_PORTS  per-port request; held until accepted
- req_ready  out  NUM_PORTS  one-hot grant; a transfer happens when req_valid[p] & req_ready[p]
- req_src_key  in  NUM_PORTS*KEY_WIDTH  packed source MACs; port p occupies [p*KEY_WIDTH +: KEY_WIDTH]
- req_dst_key  in  NUM_PORTS*KEY_WIDTH  packed destination MACs, same packing
- resp_valid  out  1  forwarding decision valid
- resp_ready  in  1  consumer accepts the decision
- resp_port  out  PW  requester the decision belongs to
- resp_dest_index  out  IW  learned index of the destination; 0 when resp_flood=1
- resp_flood  out  1  destination unknown or broadcast; flood
- cam_write_enable, cam_match_enable  out  1  CAM controls
- cam_key  out  KEY_WIDTH; cam_index  out  IW  CAM key and write index
- cam_match_index  in  IW; cam_match_valid, cam_no_match  in  1  registered CAM results
- learned_count  out  $clog2(TABLE_DEPTH+1)  entries written since reset
- table_full  out  1  learned_count == TABLE_DEPTH

## Operation
- FSM states: IDLE, SRC_LOOKUP, SRC_CHECK, LEARN, DST_LOOKUP, DST_CHECK, RESPOND.
- IDLE: round-robin search starting at last_grant+1 (mod NUM_PORTS). If any req_valid is set, assert req_ready for the winner only. Capture src, dst and port; update last_grant; go to SRC_LOOKUP. With no requests, req_ready = 0.
- SRC_LOOKUP: cam_match_enable=1, cam_key=src. Go to SRC_CHECK.
- SRC_CHECK: sample CAM results.
  - cam_no_match=1 and !table_full: go to LEARN.
  - Otherwise go to DST_LOOKUP. A hit on an existing key with a stale index is not updated; there is no aging or move.
- LEARN: cam_write_enable=1, cam_key=src, cam_index=port (zero-extended to IW). learned_count increments by 1. Go to DST_LOOKUP.
- DST_LOOKUP: cam_match_enable=1, cam_key=dst. Go to DST_CHECK.
- DST_CHECK: on cam_match_valid, resp_dest_index=cam_match_index and resp_flood=0. Otherwise resp_flood=1 and resp_dest_index=0. Go to RESPOND.
- RESPOND: resp_valid=1. resp_* fields hold stable until resp_ready. On resp_valid & resp_ready, go to IDLE.
- Never drive cam_write_enable and cam_match_enable in the same cycle. All other cycles drive cam_key=0, cam_index=0.
- Table full: learning is skipped silently. Lookups continue normally. learned_count saturates at TABLE_DEPTH.
- src == dst: learn happens first, so the DST lookup hits and returns the requester's own index. Filtering is downstream's job.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_port=0, resp_dest_index=0, resp_flood=0, cam_* outputs=0, learned_count=0, table_full=0. FSM=IDLE, last_grant=NUM_PORTS-1, so port 0 wins first.
- Reset mid-transaction aborts it; the captured request is lost. The CAM must be reset by the same event: the top level ties CAM reset_n = ~reset.
- CAM result latency is 1 cycle, so the result is sampled in the *_CHECK state following each *_LOOKUP state.
- Latency from acceptance cycle (IDLE, req_ready high) to first resp_valid:
  - 5 cycles with no learn.
  - 6 cycles with learn.
  - 3 cycles with broadcast bypass.
- A write in LEARN is visible to the DST lookup in the next cycle.
- After a response is accepted, one IDLE cycle follows before the next grant. Throughput is at most one transaction per 6 cycles without learn, 7 with learn.
- resp_ready held low stalls indefinitely. req_ready stays 0 meanwhile.
- Registered outputs only; no combinational path from inputs to outputs.

## Configuration
- CAM_BROADCAST_BYPASS_EN defined: in SRC_CHECK, when dst is all ones, skip DST_LOOKUP/DST_CHECK. LEARN, if required, still runs first. Then go directly to RESPOND with resp_flood=1 and resp_dest_index=0.
- Undefined: all-ones dst is looked up like any key. It floods unless it was previously learned as a source.

## Test plan
- After reset, port 2 requests src=0x0000_0000_00A2, dst=0x0000_0000_00B0 (both unknown):
  - CAM write of key 0x..A2, index 2.
  - resp_port=2, resp_flood=1, 6 cycles after acceptance.
  - learned_count=1.
- Same request repeated: no CAM write, response in 5 cycles, learned_count stays 1. Then port 0 sends dst=0x..A2 and gets resp_dest_index=2, resp_flood=0.
- All four ports hold req_valid continuously: grants occur in order 0,1,2,3,0, each exactly once per rotation, with one-hot req_ready.
- Learn 32 distinct sources: table_full=1 and learned_count=32. A 33rd new source gets no cam_write_enable, and a lookup of its key floods.
- resp_ready held low for 10 cycles: resp_* remain stable and no new req_ready is issued. Assert reset during SRC_CHECK: all outputs return to reset values on the next sample.
- dst=0xFFFF_FFFF_FFFF with CAM_BROADCAST_BYPASS_EN: resp_flood=1 in 3 cycles and no DST lookup issued. Without the macro: a DST lookup is issued and the response arrives in 5 cycles.
